serial_rx_port: RTL and testbench

- Receive-side serial peripheral feeding the processor's serial input channel (serial_in / serial_valid_in / serial_rden_out).
- Deserializes an asynchronous 8N1 UART line into bytes and buffers them in a show-ahead FIFO.
- Presents the FIFO head byte plus a valid flag to the processor; the processor pops with a read-enable.
- Complements the processor's serial output path, so programs can read console input.

---
 rtl/serial_rx_port.sv | 164 ++++++++++++++++
 tb/tb_serial_rx_port.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_port.sv
// 8N1 UART receiver with a show-ahead byte FIFO feeding the processor serial input channel.
// Bytes that arrive while the FIFO is full and not being popped are dropped and flagged sticky.
module serial_rx_port #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic [7:0]        data_out,
  output logic              valid_out,
  input  logic              rden_in,
  output logic [ADDR_W:0]   count_out,
  output logic              overrun_out,
  output logic              frame_err_out
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [CntW-1:0]  LastCnt  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  HalfCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]  FullCnt  = (ADDR_W + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Line synchronizer; both flops preset to the idle level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            push;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          // A start bit that is high again at mid-bit was a glitch.
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d       = '0;
          state_d     = StIdle;
          push        = rx_s_q;
          frame_err_d = !rx_s_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [7:0]        mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              pop, full, push_ok;

  assign pop     = rden_in && (count_q != '0);
  assign full    = (count_q == FullCnt);
  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overrun_d = overrun_q | (push && full && !pop);
    count_d   = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign valid_out     = (count_q != '0);
  assign data_out      = valid_out ? mem_q[rd_ptr_q] : 8'h00;
  assign count_out     = count_q;
  assign overrun_out   = overrun_q;
  assign frame_err_out = frame_err_q;

endmodule

// File: tb/tb_serial_rx_port.sv
// Directed bench for serial_rx_port: frames are driven bit by bit on the falling clock edge
// and outputs are compared against hand-computed values on the falling edge.
module tb_serial_rx_port;

  localparam int unsigned Cpb   = 8;
  localparam int unsigned AddrW = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rx = 1'b1;
  logic             rden_in = 1'b0;
  logic [7:0]       data_out;
  logic             valid_out;
  logic [AddrW:0]   count_out;
  logic             overrun_out;
  logic             frame_err_out;

  int n_checks = 0;
  int n_bad    = 0;
  int fe_seen  = 0;
  int fe0;

  serial_rx_port #(
    .CLKS_PER_BIT (Cpb),
    .ADDR_W       (AddrW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .rden_in       (rden_in),
    .count_out     (count_out),
    .overrun_out   (overrun_out),
    .frame_err_out (frame_err_out)
  );

  always #5 clock = ~clock;

  // Counts the cycles frame_err_out is high, so pulse width can be checked.
  always @(negedge clock) begin
    if (frame_err_out) fe_seen <= fe_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
    rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Cpb);
    end
    rx = stop_bit;
    for (int i = 0; i < int'(Cpb); i++) begin
      // Stop-bit sample edge follows the falling edge at i == Cpb-2.
      if (pop_at_stop) rden_in = (i == int'(Cpb) - 2);
      tick(1);
    end
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rden_in = 1'b1;
    tick(1);
    rden_in = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq(tag, {31'd0, valid_out}, 32'd1);
    check_eq(tag, {24'd0, data_out}, {24'd0, exp});
    pop_one();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    rx    = 1'b1;
    tick(n);
    reset = 1'b0;
    tick(2);
  endtask

  logic [7:0] burst [4];
  logic [7:0] five [5];

  initial begin
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    five  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    // Reset state and a single frame.
    tick(10);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_count", {29'd0, count_out}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun_out}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err_out}, 32'd0);
    check_eq("rst_data", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    tick(2);
    send_byte(8'h41, 1'b1, 1'b0);
    check_eq("t1_count", {29'd0, count_out}, 32'd1);
    pop_expect("t1_pop", 8'h41);
    check_eq("t1_valid_after", {31'd0, valid_out}, 32'd0);
    check_eq("t1_count_after", {29'd0, count_out}, 32'd0);

    // Back-to-back frames, then a burst across the pointer wrap.
    send_byte(8'h48, 1'b1, 1'b0);
    send_byte(8'h69, 1'b1, 1'b0);
    send_byte(8'h0A, 1'b1, 1'b0);
    check_eq("t2_count3", {29'd0, count_out}, 32'd3);
    pop_expect("t2_pop0", 8'h48);
    pop_expect("t2_pop1", 8'h69);
    pop_expect("t2_pop2", 8'h0A);
    check_eq("t2_empty", {29'd0, count_out}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(burst[i], 1'b1, 1'b0);
    check_eq("t2_count4", {29'd0, count_out}, 32'd4);
    check_eq("t2_no_ovr", {31'd0, overrun_out}, 32'd0);
    for (int i = 0; i < 4; i++) pop_expect("t2_wrap", burst[i]);
    check_eq("t2_empty2", {29'd0, count_out}, 32'd0);

    // Overrun: fifth byte dropped, flag sticky until reset.
    do_reset(3);
    for (int i = 0; i < 5; i++) send_byte(five[i], 1'b1, 1'b0);
    check_eq("t3_count", {29'd0, count_out}, 32'd4);
    check_eq("t3_ovr", {31'd0, overrun_out}, 32'd1);
    for (int i = 0; i < 4; i++) pop_expect("t3_pop", five[i]);
    check_eq("t3_valid", {31'd0, valid_out}, 32'd0);
    tick(5);
    check_eq("t3_ovr_sticky", {31'd0, overrun_out}, 32'd1);
    do_reset(3);
    check_eq("t3_ovr_cleared", {31'd0, overrun_out}, 32'd0);

    // Framing error pulse, then recovery.
    fe0 = fe_seen;
    send_byte(8'h55, 1'b0, 1'b0);
    tick(2 * Cpb);
    check_eq("t4_ferr_cycles", fe_seen - fe0, 32'd1);
    check_eq("t4_count", {29'd0, count_out}, 32'd0);
    send_byte(8'hAA, 1'b1, 1'b0);
    check_eq("t4_count_good", {29'd0, count_out}, 32'd1);
    check_eq("t4_no_new_ferr", fe_seen - fe0, 32'd1);
    pop_expect("t4_pop", 8'hAA);

    // Start glitch and pop while empty.
    fe0 = fe_seen;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check_eq("t5_count", {29'd0, count_out}, 32'd0);
    check_eq("t5_ferr", fe_seen - fe0, 32'd0);
    rden_in = 1'b1;
    tick(3);
    rden_in = 1'b0;
    check_eq("t5_empty_pop", {29'd0, count_out}, 32'd0);
    check_eq("t5_valid", {31'd0, valid_out}, 32'd0);
    send_byte(8'h5A, 1'b1, 1'b0);
    check_eq("t5_count1", {29'd0, count_out}, 32'd1);
    pop_expect("t5_pop", 8'h5A);

    // Full FIFO with a pop on the stop-bit push edge.
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b1, 1'b0);
    check_eq("t6_full", {29'd0, count_out}, 32'd4);
    send_byte(8'h05, 1'b1, 1'b1);
    check_eq("t6_count", {29'd0, count_out}, 32'd4);
    check_eq("t6_no_ovr", {31'd0, overrun_out}, 32'd0);
    pop_expect("t6_pop0", 8'h02);
    pop_expect("t6_pop1", 8'h03);
    pop_expect("t6_pop2", 8'h04);
    pop_expect("t6_pop3", 8'h05);
    check_eq("t6_empty", {29'd0, count_out}, 32'd0);

    // Reset in the middle of a data phase.
    send_byte(8'h77, 1'b1, 1'b0);
    rx = 1'b0;
    tick(Cpb + 20);
    do_reset(3);
    check_eq("t6_rst_count", {29'd0, count_out}, 32'd0);
    check_eq("t6_rst_valid", {31'd0, valid_out}, 32'd0);
    tick(20);
    check_eq("t6_idle_count", {29'd0, count_out}, 32'd0);
    send_byte(8'h3C, 1'b1, 1'b0);
    check_eq("t6_post_count", {29'd0, count_out}, 32'd1);
    pop_expect("t6_post_pop", 8'h3C);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
